// File: rtl/serial_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_if
// Description : Start/busy/done handshake and operand/result bundle for the
//               bit-serial ALU. The requester drives start/op/a/b and
//               observes the result and flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             err;

    // Requester side
    modport master (
        output start, op, a, b,
        input  busy, done, res, cout, ovf, zero, err
    );

    // ALU side
    modport slave (
        input  start, op, a, b,
        output busy, done, res, cout, ovf, zero, err
    );
endinterface
`default_nettype wire

// File: rtl/serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu
// Description : Parametrised bit-serial ALU. A single one-bit slice plus a
//               carry flip-flop processes the operands LSB-first, one bit per
//               clock. Result and flags are registered and only change on the
//               completion edge, WIDTH edges after the capture edge.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu #(
    parameter int WIDTH = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    serial_alu_if.slave  bus
);

    localparam int                 c_idx_w    = $clog2(WIDTH) + 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_and  = 4'b0010;
    localparam logic [3:0] c_op_or   = 4'b0011;
    localparam logic [3:0] c_op_xor  = 4'b0100;
    localparam logic [3:0] c_op_nor  = 4'b0101;
    localparam logic [3:0] c_op_pass = 4'b0110;
    localparam logic [3:0] c_op_not  = 4'b0111;
    localparam logic [3:0] c_op_inc  = 4'b1000;
    localparam logic [3:0] c_op_dec  = 4'b1001;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_last;

    // Operation context captured at start
    logic [WIDTH-1:0]     r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic [3:0]           r_op;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;
    // Upper WIDTH-1 result bits collected so far; the final bit joins at completion
    logic [WIDTH-1:1]     r_res_sh;

    // Architectural outputs, written only on the completion edge
    logic [WIDTH-1:0]     r_res;
    logic                 r_cout;
    logic                 r_ovf;
    logic                 r_zero;
    logic                 r_err;
    logic                 r_done;

    // Slice signals
    logic                 w_a0;
    logic                 w_b_eff;
    logic                 w_sum;
    logic                 w_carry_out;
    logic                 w_arith;
    logic                 w_illegal;
    logic                 w_bit;
    logic [WIDTH-1:0]     w_res_shifted;
    logic                 w_cin_load;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept start only in IDLE, leave RUN after the MSB is processed
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_idx == c_last_idx) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Carry-in preload for the op presented at start
    always_comb begin
        w_cin_load = 1'b0;
        if (bus.op == c_op_sub || bus.op == c_op_inc) begin
            w_cin_load = 1'b1;
        end
    end

    // One-bit slice: arithmetic ops share a full adder with a per-op B operand
    always_comb begin
        w_a0      = r_a_sh[0];
        w_b_eff   = 1'b0;
        w_arith   = 1'b0;
        w_illegal = 1'b0;
        w_bit     = 1'b0;
        case (r_op)
            c_op_add: begin w_b_eff = r_b_sh[0];  w_arith = 1'b1; end
            c_op_sub: begin w_b_eff = ~r_b_sh[0]; w_arith = 1'b1; end
            c_op_inc: begin w_b_eff = 1'b0;       w_arith = 1'b1; end
            c_op_dec: begin w_b_eff = 1'b1;       w_arith = 1'b1; end
            default:  begin w_b_eff = 1'b0;       w_arith = 1'b0; end
        endcase
        w_sum       = w_a0 ^ w_b_eff ^ r_carry;
        w_carry_out = (w_a0 & w_b_eff) | (w_a0 & r_carry) | (w_b_eff & r_carry);
        case (r_op)
            c_op_add, c_op_sub, c_op_inc, c_op_dec: w_bit = w_sum;
            c_op_and:  w_bit = r_a_sh[0] & r_b_sh[0];
            c_op_or:   w_bit = r_a_sh[0] | r_b_sh[0];
            c_op_xor:  w_bit = r_a_sh[0] ^ r_b_sh[0];
            c_op_nor:  w_bit = ~(r_a_sh[0] | r_b_sh[0]);
            c_op_pass: w_bit = r_a_sh[0];
            c_op_not:  w_bit = ~r_a_sh[0];
            default: begin
                w_bit     = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
        w_res_shifted = {w_bit, r_res_sh};
    end

    // Datapath: capture on accept, shift one bit per RUN edge, publish on the last edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_op     <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_res_sh <= '0;
            r_res    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a_sh   <= bus.a;
                r_b_sh   <= bus.b;
                r_op     <= bus.op;
                r_carry  <= w_cin_load;
                r_idx    <= '0;
                r_res_sh <= '0;
            end else if (r_state == ST_RUN) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_res_sh <= w_res_shifted[WIDTH-1:1];
                r_carry  <= w_carry_out;
                r_idx    <= r_idx + c_idx_one;
                if (w_last) begin
                    r_done <= 1'b1;
                    r_res  <= w_res_shifted;
                    r_cout <= w_arith & w_carry_out;
                    // r_carry holds the carry into the MSB at this point
                    r_ovf  <= w_arith & (r_carry ^ w_carry_out);
                    r_zero <= (w_res_shifted == '0);
                    r_err  <= w_illegal;
                end
            end
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = r_done;
    assign bus.res  = r_res;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
    assign bus.err  = r_err;

endmodule
`default_nettype wire
